instr_fetch_decoder: RTL

//  Front-end sequencer of the uTPU controller. Pulls bytes from the UART RX FIFO, assembles 16-bit

---
 rtl/instr_fetch_decoder_if.sv | 26 ++
 rtl/instr_fetch_decoder.sv | 108 ++++++++++
 2 files changed

// File: rtl/instr_fetch_decoder_if.sv
// RX FIFO read port and decoded-command handshake between the fetch/decode
// sequencer (master) and its FIFO and execute neighbours (slave).
interface instr_fetch_decoder_if #(
  parameter int FIFO_DATA_WIDTH = 8,
  parameter int OPCODE_WIDTH    = 3,
  parameter int ADDRESS_SIZE    = 9
);
  logic                       rx_empty;
  logic                       rx_re;
  logic [FIFO_DATA_WIDTH-1:0] rx_data;
  logic                       cmd_valid;
  logic                       cmd_ready;
  logic [OPCODE_WIDTH-1:0]    cmd_opcode;
  logic [2:0]                 cmd_flags;
  logic [ADDRESS_SIZE-1:0]    cmd_addr;

  modport master (
    input  rx_empty, rx_data, cmd_ready,
    output rx_re, cmd_valid, cmd_opcode, cmd_flags, cmd_addr
  );

  modport slave (
    output rx_empty, rx_data, cmd_ready,
    input  rx_re, cmd_valid, cmd_opcode, cmd_flags, cmd_addr
  );
endinterface

// File: rtl/instr_fetch_decoder.sv
// uTPU front end: pulls bytes from the RX FIFO, assembles 16-bit instructions
// (plus optional extended STORE address) and issues one command per instruction.
module instr_fetch_decoder #(
  parameter int FIFO_DATA_WIDTH  = 8,
  parameter int BUFFER_WORD_SIZE = 16,
  parameter int OPCODE_WIDTH     = 3,
  parameter int ADDRESS_SIZE     = 9
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  instr_fetch_decoder_if.master        bus,
  output logic                         halted,
  output logic                         illegal_op,
  output logic [15:0]                  instr_count
);
  typedef enum logic [2:0] {IDLE, REQ, CAP, DECODE, ISSUE, HALTED} state_t;

  localparam logic [OPCODE_WIDTH-1:0] OP_STORE = OPCODE_WIDTH'(0);
  localparam logic [OPCODE_WIDTH-1:0] OP_HALT  = OPCODE_WIDTH'(4);
  localparam logic [OPCODE_WIDTH-1:0] OP_NOP   = OPCODE_WIDTH'(5);

  state_t                      state;
  logic [1:0]                  byte_idx;
  logic [BUFFER_WORD_SIZE-1:0] instr;
  logic [OPCODE_WIDTH-1:0]     opc;
  logic                        unused_instr;

  assign opc          = instr[OPCODE_WIDTH-1:0];
  assign unused_instr = ^instr;

  // Read strobe is qualified by rx_empty in the same cycle so it can never pop an
  // empty FIFO; REQ always exits to CAP on a read, so it is a single-cycle pulse.
  assign bus.rx_re = (state == REQ) && !bus.rx_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      byte_idx       <= 2'd0;
      instr          <= '0;
      bus.cmd_valid  <= 1'b0;
      bus.cmd_opcode <= '0;
      bus.cmd_flags  <= '0;
      bus.cmd_addr   <= '0;
      halted         <= 1'b0;
      illegal_op     <= 1'b0;
      instr_count    <= '0;
    end else begin
      case (state)
        IDLE: if (start) state <= REQ;

        REQ: if (!bus.rx_empty) state <= CAP;

        CAP: begin
          case (byte_idx)
            2'd0: instr[FIFO_DATA_WIDTH-1:0] <= bus.rx_data;
            2'd1: instr[BUFFER_WORD_SIZE-1:FIFO_DATA_WIDTH] <= bus.rx_data;
            2'd2: bus.cmd_addr[7:0] <= bus.rx_data[7:0];
            default: bus.cmd_addr[ADDRESS_SIZE-1:8] <= bus.rx_data[ADDRESS_SIZE-9:0];
          endcase
          byte_idx <= byte_idx + 2'd1;
          if (byte_idx == 2'd1) begin
            state <= DECODE;
          end else if (byte_idx == 2'd3) begin
            state         <= ISSUE;
            bus.cmd_valid <= 1'b1;
          end else begin
            state <= REQ;
          end
        end

        DECODE: begin
          bus.cmd_opcode <= opc;
          bus.cmd_flags  <= instr[5:3];
          bus.cmd_addr   <= instr[BUFFER_WORD_SIZE-1 -: ADDRESS_SIZE];
          if (opc == OP_STORE && instr[4]) begin
            // extended address bytes follow and overwrite the instruction field
            byte_idx <= 2'd2;
            state    <= REQ;
          end else if (opc >= OP_NOP) begin
            byte_idx <= 2'd0;
            state    <= REQ;
            if (opc != OP_NOP) illegal_op <= 1'b1;
          end else begin
            state         <= ISSUE;
            bus.cmd_valid <= 1'b1;
          end
        end

        ISSUE: if (bus.cmd_ready) begin
          bus.cmd_valid <= 1'b0;
          instr_count   <= instr_count + 16'd1;
          byte_idx      <= 2'd0;
          if (bus.cmd_opcode == OP_HALT) begin
            state  <= HALTED;
            halted <= 1'b1;
          end else begin
            state <= REQ;
          end
        end

        HALTED: state <= HALTED;

        default: state <= IDLE;
      endcase
    end
  end
endmodule
